sync_mem_bank: RTL and testbench

Parametrised single-port synchronous memory that succeeds the basic cen/wen word memory in the nibble CPU subsystem. It adds configurable width, depth and read latency, and byte-lane write strobes. It also adds a read-valid pipeline, out-of-range address detection, and a self-clearing initialisation state machine. It sits between the CPU load/store unit and the test bench memory model.

---
 rtl/sync_mem_bank.sv | 200 ++++++++++++++++++++
 tb/tb_sync_mem_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_mem_bank.sv
// sync_mem_bank: single-port synchronous word memory with byte-lane strobes,
// a self-clearing initialisation FSM, configurable read latency (1 or 2),
// a read-valid pipeline and out-of-range address detection.
// Optional feature macro: MEM_PARITY_EN adds one even-parity bit per byte,
// a perr_inj input and a perr output.
module sync_mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
`ifdef MEM_PARITY_EN
  input  logic                perr_inj,
  output logic                perr,
`endif
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                ready,
  output logic                addr_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  logic              clearing;
  logic              in_range;
  logic              accept;
  logic              wr_ok;
  logic              rd_ok;
  logic              rd_acc;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] data1;

  logic              v1_reg;
  logic              e1_reg;
  logic              z1_reg;   // last accepted read was out of range -> output zero
`ifdef MEM_PARITY_EN
  logic [NB-1:0]     lane_bad;
  logic              perr1;
`endif

  // State register and clear counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: walk every word once, then run until reset.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_IDX) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  assign ready    = (state_reg == RUN);
  assign clearing = (state_reg == CLEAR);
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign accept   = ready & cen;
  assign wr_ok    = accept & wen & in_range;
  assign rd_acc   = accept & ~wen;
  assign rd_ok    = rd_acc & in_range;
  // The clear sweep owns the address port while in CLEAR.
  assign mem_idx  = clearing ? cnt_reg[IDX_W-1:0] : addr[IDX_W-1:0];

  // One independent storage array per byte lane so strobes map to lane enables.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [LW-1:0] mem [DEPTH];
    logic [LW-1:0] q_reg;
    logic [LW-1:0] wd;
    logic [7:0]    wbyte;
    logic          we;

    assign wbyte = wdata[gi*8 +: 8];
    assign we    = clearing | (wr_ok & wstrb[gi]);
`ifdef MEM_PARITY_EN
    // Even parity: stored bit makes the 9-bit total even; inject flips it.
    assign wd           = clearing ? '0 : {(^wbyte) ^ perr_inj, wbyte};
    assign lane_bad[gi] = ^q_reg;
`else
    assign wd = clearing ? '0 : wbyte;
`endif

    // Lane storage: single write port, registered read on accepted reads.
    always_ff @(posedge clk) begin
      if (we) begin
        mem[mem_idx] <= wd;
      end
      if (rd_ok) begin
        q_reg <= mem[mem_idx];
      end
    end

    assign rd_word[gi*8 +: 8] = q_reg[7:0];
  end

  // First pipeline stage: valid, error and zero-select flags for the read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0;
      e1_reg <= 1'b0;
      z1_reg <= 1'b1;
    end else begin
      v1_reg <= rd_acc;
      e1_reg <= accept & ~in_range;
      if (rd_acc) begin
        z1_reg <= ~in_range;
      end
    end
  end

  // Lane read registers only load on in-range reads, so data1 holds between reads.
  assign data1 = z1_reg ? '0 : rd_word;
`ifdef MEM_PARITY_EN
  assign perr1 = v1_reg & ~z1_reg & (|lane_bad);
`endif

  if (RD_LAT == 2) begin : g_lat2
    logic              v2_reg;
    logic              e2_reg;
    logic [DATA_W-1:0] d2_reg;
`ifdef MEM_PARITY_EN
    logic              p2_reg;
`endif

    // Extra output stage; data only advances with a valid read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v2_reg <= 1'b0;
        e2_reg <= 1'b0;
        d2_reg <= '0;
`ifdef MEM_PARITY_EN
        p2_reg <= 1'b0;
`endif
      end else begin
        v2_reg <= v1_reg;
        e2_reg <= e1_reg;
        if (v1_reg) begin
          d2_reg <= data1;
        end
`ifdef MEM_PARITY_EN
        p2_reg <= perr1;
`endif
      end
    end

    assign rvalid   = v2_reg;
    assign addr_err = e2_reg;
    assign rdata    = d2_reg;
`ifdef MEM_PARITY_EN
    assign perr     = p2_reg;
`endif
  end else begin : g_lat1
    assign rvalid   = v1_reg;
    assign addr_err = e1_reg;
    assign rdata    = data1;
`ifdef MEM_PARITY_EN
    assign perr     = perr1;
`endif
  end

endmodule

// File: tb/tb_sync_mem_bank.sv
// Scoreboard bench for sync_mem_bank: two instances (DEPTH=10/RD_LAT=1 and
// DEPTH=16/RD_LAT=2) share one stimulus stream; a word-array reference model
// predicts each response and a negedge monitor compares what the DUTs present.
module tb_sync_mem_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b, ready_a, ready_b, addr_err_a, addr_err_b;
`ifdef MEM_PARITY_EN
  logic        perr_inj = 1'b0;
  logic        perr_a, perr_b;
`endif

  always #5 clk = ~clk;

  sync_mem_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(10), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .wstrb(wstrb), .addr(addr),
    .wdata(wdata),
`ifdef MEM_PARITY_EN
    .perr_inj(perr_inj), .perr(perr_a),
`endif
    .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a), .addr_err(addr_err_a)
  );

  sync_mem_bank #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen), .wstrb(wstrb), .addr(addr),
    .wdata(wdata),
`ifdef MEM_PARITY_EN
    .perr_inj(perr_inj), .perr(perr_b),
`endif
    .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b), .addr_err(addr_err_b)
  );

  typedef struct {
    int unsigned due;
    bit          rd;
    bit          err;
    logic [31:0] data;
    bit          perr;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [31:0] model [2][16];
  bit   [3:0]  bad   [2][16];
  int          depth [2] = '{10, 16};
  int          lat   [2] = '{1, 2};
  logic [31:0] last  [2] = '{32'h0, 32'h0};

  always @(posedge clk) cyc <= cyc + 1;

  // Present one request for a cycle and predict both DUTs' responses.
  task automatic issue(input bit c, input bit w, input logic [4:0] a,
                       input logic [3:0] s, input logic [31:0] d, input bit inj);
    exp_t e;
    cen = c; wen = w; addr = a; wstrb = s; wdata = d;
`ifdef MEM_PARITY_EN
    perr_inj = inj;
`endif
    if (c) begin
      for (int k = 0; k < 2; k++) begin
        bit inr;
        inr    = int'(a) < depth[k];
        e.due  = cyc + int'(lat[k]);
        e.rd   = !w;
        e.err  = !inr;
        e.data = '0;
        e.perr = 1'b0;
        if (w && inr) begin
          for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
              model[k][a][8*i +: 8] = d[8*i +: 8];
              bad[k][a][i] = inj;
            end
          end
        end
        if (!w && inr) begin
          e.data = model[k][a];
          e.perr = |bad[k][a];
        end
        if (!w || !inr) begin
          if (k == 0) qa.push_back(e);
          else        qb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 1'b0);
  endtask

  // Assert reset, then count edges until each instance reports ready.
  task automatic do_reset();
    int n, na, nb;
    rst = 1'b1;
    cen = 1'b1; wen = 1'b1; addr = 5'd5; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    qa.delete();
    qb.delete();
    last[0] = '0;
    last[1] = '0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 16; j++) begin
        model[k][j] = '0;
        bad[k][j]   = '0;
      end
    #1;
    checks++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset: got a=%0b b=%0b, required 0 0", ready_a, ready_b);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0; na = 0; nb = 0;
    while ((na == 0 || nb == 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_a && na == 0) begin
        na  = n;
        cen = 1'b0;   // stop pushing writes once the shorter clear is done
      end
      if (ready_b && nb == 0) nb = n;
    end
    cen = 1'b0;
    checks++;
    if (na != 10 || nb != 16) begin
      errors++;
      $display("FAIL clear_length: got a=%0d b=%0d edges, required 10 16", na, nb);
    end else begin
      $display("clear done: ready after a=%0d b=%0d edges", na, nb);
    end
  endtask

  // Compare one instance's outputs against the head of its scoreboard queue.
  task automatic mon(input int k, input logic rv, input logic er,
                     input logic [31:0] rd, input logic pe);
    exp_t e;
    bit   have;
    have = (k == 0) ? (qa.size() > 0) : (qb.size() > 0);
    if (have) e = (k == 0) ? qa[0] : qb[0];
    if (rv || er) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_out dut%0d cyc=%0d: got rvalid=%0b addr_err=%0b, required none",
                 k, cyc, rv, er);
      end else begin
        if (k == 0) void'(qa.pop_front());
        else        void'(qb.pop_front());
        if (rv !== e.rd || er !== e.err || e.due != cyc ||
            (e.rd && (rd !== e.data || pe !== e.perr))) begin
          errors++;
          $display("FAIL response dut%0d cyc=%0d: got rvalid=%0b err=%0b data=%h perr=%0b, required rvalid=%0b err=%0b data=%h perr=%0b at cyc=%0d",
                   k, cyc, rv, er, rd, pe, e.rd, e.err, e.data, e.perr, e.due);
        end else begin
          $display("dut%0d cyc=%0d rvalid=%0b addr_err=%0b data=%h perr=%0b ok",
                   k, cyc, rv, er, rd, pe);
        end
        if (e.rd) last[k] = e.data;
      end
    end else begin
      if (have && e.due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out dut%0d cyc=%0d: got no response, required rvalid=%0b err=%0b due cyc=%0d",
                 k, cyc, e.rd, e.err, e.due);
        if (k == 0) void'(qa.pop_front());
        else        void'(qb.pop_front());
      end
      checks++;
      if (rd !== last[k]) begin
        errors++;
        $display("FAIL rdata_hold dut%0d cyc=%0d: got %h, required %h", k, cyc, rd, last[k]);
      end
    end
  endtask

  always @(negedge clk) begin
`ifdef MEM_PARITY_EN
    mon(0, rvalid_a, addr_err_a, rdata_a, perr_a);
    mon(1, rvalid_b, addr_err_b, rdata_b, perr_b);
`else
    mon(0, rvalid_a, addr_err_a, rdata_a, 1'b0);
    mon(1, rvalid_b, addr_err_b, rdata_b, 1'b0);
`endif
  end

  initial begin
    bit inj;
    do_reset();
    // Writes presented during clear must not have landed.
    issue(1, 0, 5'd5, 4'h0, 32'h0, 0);
    idle(3);
    // Byte strobes.
    issue(1, 1, 5'd3, 4'hF, 32'hAABBCCDD, 0);
    issue(1, 1, 5'd3, 4'b0101, 32'h11223344, 0);
    issue(1, 0, 5'd3, 4'h0, 32'h0, 0);
    idle(3);
    // Back-to-back reads.
    issue(1, 1, 5'd0, 4'hF, 32'h10, 0);
    issue(1, 1, 5'd1, 4'hF, 32'h20, 0);
    issue(1, 1, 5'd2, 4'hF, 32'h30, 0);
    issue(1, 0, 5'd0, 4'h0, 32'h0, 0);
    issue(1, 0, 5'd1, 4'h0, 32'h0, 0);
    issue(1, 0, 5'd2, 4'h0, 32'h0, 0);
    idle(3);
    // Out of range for the DEPTH=10 instance.
    issue(1, 0, 5'd12, 4'h0, 32'h0, 0);
    issue(1, 1, 5'd12, 4'hF, 32'hFF, 0);
    issue(1, 0, 5'd2, 4'h0, 32'h0, 0);
    issue(1, 0, 5'd12, 4'h0, 32'h0, 0);
    idle(3);
`ifdef MEM_PARITY_EN
    issue(1, 1, 5'd4, 4'hF, 32'h01, 1);
    issue(1, 0, 5'd4, 4'h0, 32'h0, 0);
    issue(1, 1, 5'd4, 4'hF, 32'h01, 0);
    issue(1, 0, 5'd4, 4'h0, 32'h0, 0);
    idle(3);
`endif
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
`ifdef MEM_PARITY_EN
      inj = ($urandom_range(0, 3) == 0);
`else
      inj = 1'b0;
`endif
      issue($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 19)), 4'($urandom), $urandom, inj);
    end
    idle(3);
    // Reset while a RD_LAT=2 read is in flight.
    issue(1, 1, 5'd1, 4'hF, 32'h5555AAAA, 0);
    issue(1, 0, 5'd1, 4'h0, 32'h0, 0);
    do_reset();
    issue(1, 0, 5'd1, 4'h0, 32'h0, 0);
    idle(4);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d outstanding, required 0/0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
